// File: rtl/seq_mult_shift_add.sv
// ---------------------------------------------------------------------------
// seq_mult_shift_add
//
// Sequential radix-2 shift-add multiplier with a start/done handshake.
// Each RUN cycle adds the shifted multiplicand to the product accumulator if
// the current multiplier LSB is set. The operation stops as soon as the
// remaining multiplier bits are all zero, so latency depends on the position
// of the multiplier's MSB and not on its value.
//
// Parameters:
//   WIDTH    operand width in bits (>= 2); the product is 2*WIDTH bits wide
//
// Ports:
//   clk      clock; all state updates happen on the rising edge
//   rst      asynchronous active-high reset
//   start    request; only sampled while the FSM is IDLE
//   a_in     multiplicand, captured on an accepted start
//   b_in     multiplier, captured on an accepted start
//   busy     high while the FSM is in RUN
//   done     one-cycle pulse; product is valid
//   product  result register; holds its value until the next accepted start
//
// Optional feature:
//   SEQ_MULT_SIGNED_EN  when defined, a_in/b_in are two's complement. The
//                       magnitudes are multiplied and the result is negated
//                       on the final RUN cycle if the operand signs differ.
// ---------------------------------------------------------------------------
module seq_mult_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    product_q, product_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Operand values as they are loaded into the datapath on accept.
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;

    logic [PW-1:0]    sum;
    logic [WIDTH-1:0] b_shift;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Two's complement magnitude; the most-negative value maps to
    // 2^(WIDTH-1), which is still representable as an unsigned WIDTH value.
    assign a_op = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    assign b_op = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
`else
    assign a_op = a_in;
    assign b_op = b_in;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        count_d   = count_q;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d     = neg_q;
`endif
        // Accumulator never overflows: the sum of shifted partial products
        // of two WIDTH-bit values always fits in 2*WIDTH bits.
        sum     = product_q + (b_q[0] ? a_q : {PW{1'b0}});
        b_shift = b_q >> 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = {{WIDTH{1'b0}}, a_op};
                    b_d       = b_op;
                    product_d = '0;
                    count_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d     = a_in[WIDTH-1] ^ b_in[WIDTH-1];
`endif
                    // A zero multiplier skips RUN entirely; product stays 0,
                    // so no sign fix-up is needed on that path.
                    state_d   = (b_op != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                product_d = sum;
                a_d       = a_q << 1;
                b_d       = b_shift;
                count_d   = count_q + CNT_W'(1);
                if (b_shift == '0) begin
                    state_d = DONE;
`ifdef SEQ_MULT_SIGNED_EN
                    // Apply the sign on the last accumulate so the product
                    // is already final when DONE is entered.
                    if (neg_q) begin
                        product_d = ~sum + 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            count_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            count_q   <= count_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    // count is a debug aid: with early termination a RUN cycle can never
    // start with WIDTH iterations already done.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RUN) begin
            assert (count_q < CNT_MAX)
                else $error("seq_mult_shift_add: count reached WIDTH in RUN");
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
